fprti_ctrl: RTL and testbench

//  CPU-side front end of the ray/triangle intersection unit. Collects FP32 operands
//  (P0,P1,P2,R0,Rd) from CPU custom-instruction writes into an operand file, issues
//  a single-cycle start to the intersection core, waits for its result and returns
//  it to the CPU over a valid/ready response channel.

---
 rtl/fprti_pkg.sv | 15 +
 rtl/fprti_opnd_file.sv | 32 +++
 rtl/fprti_ctrl.sv | 83 ++++++++
 tb/tb_fprti_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fprti_pkg.sv
// fprti_pkg: shared state encodings, error codes and constants for the FPRTI front end
package fprti_pkg;
   localparam int FPRTI_NUM_REGS = 16;
   localparam logic [31:0] FPRTI_QNAN = 32'h7FC0_0000;
   typedef logic [1:0] fprti_ctrl_state_t;
   localparam fprti_ctrl_state_t S_IDLE  = 2'd0;
   localparam fprti_ctrl_state_t S_ISSUE = 2'd1;
   localparam fprti_ctrl_state_t S_WAIT  = 2'd2;
   localparam fprti_ctrl_state_t S_RESP  = 2'd3;
   typedef enum logic [1:0] {
      ERR_OK         = 2'b00,
      ERR_INCOMPLETE = 2'b01,
      ERR_TIMEOUT    = 2'b10
   } fprti_err_t;
endpackage

// File: rtl/fprti_opnd_file.sv
// fprti_opnd_file: operand register file with written-mask; all_req_written already reflects a same-cycle write or clear
module fprti_opnd_file
   import fprti_pkg::*;
#(
   parameter int N   = FPRTI_NUM_REGS,
   parameter int REQ = 15,
   parameter int IW  = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               we,
   input  logic               clr,
   input  logic [IW-1:0]      idx,
   input  logic [31:0]        data,
   output logic [N-1:0][31:0] regs,
   output logic               all_req_written
);
   logic [N-1:0]   hit;
   logic [REQ-1:0] mask;
   for (genvar i = 0; i < N; i++) begin : g_hit
      assign hit[i] = we && idx == IW'(i);
   end
   assign all_req_written = !clr && &(mask | hit[REQ-1:0]);
   always_ff @(posedge clk)
      if (!rst_n || clr) begin
         regs <= '0;
         mask <= '0;
      end else begin
         for (int k = 0; k < N; k++) if (hit[k]) regs[k] <= data;
         mask <= mask | hit[REQ-1:0];
      end
endmodule

// File: rtl/fprti_ctrl.sv
// fprti_ctrl: CPU front end of the ray/triangle unit; define FPRTI_CTRL_TIMEOUT_EN to bound the WAIT state
module fprti_ctrl
   import fprti_pkg::*;
#(
   parameter int NUM_FPRTI_REGS = FPRTI_NUM_REGS,
   parameter int REQ_REGS       = 15,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                wr_valid_i,
   input  logic [$clog2(NUM_FPRTI_REGS)-1:0]   wr_idx_i,
   input  logic [31:0]                         wr_data_i,
   output logic                                wr_ready_o,
   input  logic                                start_i,
   input  logic                                clear_i,
   output logic                                busy_o,
   output logic [NUM_FPRTI_REGS-1:0][31:0]     fprti_regs_o,
   output logic                                core_valid_o,
   input  logic [31:0]                         core_result_i,
   input  logic                                core_valid_i,
   output logic                                rsp_valid_o,
   output logic [31:0]                         rsp_data_o,
   output logic [1:0]                          rsp_err_o,
   input  logic                                rsp_ready_i
);
   localparam int IW = $clog2(NUM_FPRTI_REGS);
   fprti_ctrl_state_t state;
   fprti_err_t        err;
   logic              idle, all_req_written, timeout;
   if (TIMEOUT_CYCLES < 1 || REQ_REGS > NUM_FPRTI_REGS) begin : g_cfg_err
      $error("fprti_ctrl: invalid parameter set");
   end
   assign idle         = state == S_IDLE;
   assign wr_ready_o   = idle;
   assign busy_o       = !idle;
   assign core_valid_o = state == S_ISSUE;
   assign rsp_valid_o  = state == S_RESP;
   assign rsp_err_o    = err;
   fprti_opnd_file #(.N(NUM_FPRTI_REGS), .REQ(REQ_REGS), .IW(IW)) u_opnd (
      .clk, .rst_n,
      .we(wr_valid_i && idle), .clr(clear_i && idle),
      .idx(wr_idx_i), .data(wr_data_i),
      .regs(fprti_regs_o), .all_req_written
   );
`ifdef FPRTI_CTRL_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CW-1:0] cnt;
   // counts WAIT cycles; held at zero elsewhere so it restarts on every WAIT entry
   always_ff @(posedge clk) cnt <= (!rst_n || state != S_WAIT) ? '0 : cnt + CW'(1);
   assign timeout = state == S_WAIT && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
   assign timeout = 1'b0;
`endif
   always_ff @(posedge clk)
      if (!rst_n) begin
         state      <= S_IDLE;
         rsp_data_o <= '0;
         err        <= ERR_OK;
      end else
         case (state)
            S_IDLE:
               if (start_i) begin
                  state <= all_req_written ? S_ISSUE : S_RESP;
                  if (!all_req_written) begin
                     rsp_data_o <= FPRTI_QNAN;
                     err        <= ERR_INCOMPLETE;
                  end
               end
            S_ISSUE: state <= S_WAIT;
            S_WAIT:
               if (core_valid_i) begin
                  state      <= S_RESP;
                  rsp_data_o <= core_result_i;
                  err        <= ERR_OK;
               end else if (timeout) begin
                  state      <= S_RESP;
                  rsp_data_o <= FPRTI_QNAN;
                  err        <= ERR_TIMEOUT;
               end
            default: if (rsp_ready_i) state <= S_IDLE;
         endcase
endmodule

// File: tb/tb_fprti_ctrl.sv
// tb_fprti_ctrl: scoreboard bench; responses are checked against a queue filled when each start is driven
module tb_fprti_ctrl;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   logic clk = 1'b0, rst_n = 1'b0, wr_valid_i = 1'b0, start_i = 1'b0, clear_i = 1'b0;
   logic core_valid_i = 1'b0, rsp_ready_i = 1'b0;
   logic [3:0] wr_idx_i = '0;
   logic [31:0] wr_data_i = '0, core_result_i = '0;
   logic wr_ready_o, busy_o, core_valid_o, rsp_valid_o;
   logic [15:0][31:0] fprti_regs_o, model = '0;
   logic [31:0] rsp_data_o;
   logic [1:0] rsp_err_o;
   logic [33:0] exp_q[$];
   logic [31:0] fl [15] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                            32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000,
                            32'h41300000, 32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000};
   int vecs = 0, errs = 0;

   fprti_ctrl #(.NUM_FPRTI_REGS(16), .REQ_REGS(15), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n), .wr_valid_i(wr_valid_i), .wr_idx_i(wr_idx_i), .wr_data_i(wr_data_i),
      .wr_ready_o(wr_ready_o), .start_i(start_i), .clear_i(clear_i), .busy_o(busy_o),
      .fprti_regs_o(fprti_regs_o), .core_valid_o(core_valid_o), .core_result_i(core_result_i),
      .core_valid_i(core_valid_i), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
      .rsp_err_o(rsp_err_o), .rsp_ready_i(rsp_ready_i));

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   always @(negedge clk)
      if (rst_n && rsp_valid_o && rsp_ready_i) begin
         vecs++;
         if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL rsp_unexpected: got data=%h err=%b want no response", rsp_data_o, rsp_err_o);
         end else begin
            logic [33:0] e;
            e = exp_q.pop_front();
            if ({rsp_data_o, rsp_err_o} !== e) begin
               errs++;
               $display("FAIL rsp: got data=%h err=%b want data=%h err=%b", rsp_data_o, rsp_err_o, e[33:2], e[1:0]);
            end
         end
      end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic write_op(input logic [3:0] idx, input logic [31:0] data);
      wr_valid_i = 1'b1; wr_idx_i = idx; wr_data_i = data;
      tick;
      wr_valid_i = 1'b0;
      model[idx] = data;
   endtask

   task automatic fill(input int n);
      for (int i = 0; i < n; i++) write_op(4'(i), fl[i]);
   endtask

   task automatic clear_op;
      clear_i = 1'b1;
      tick;
      clear_i = 1'b0;
      model = '0;
   endtask

   task automatic accept;
      rsp_ready_i = 1'b1;
      for (int i = 0; i < 5 && busy_o; i++) tick;
      rsp_ready_i = 1'b0;
   endtask

   task automatic core_reply(input logic [31:0] data, input int lat);
      repeat (lat) tick;
      core_result_i = data; core_valid_i = 1'b1;
      tick;
      core_valid_i = 1'b0;
      accept;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) tick;
      rst_n = 1'b1;
      vecs++; if (wr_ready_o !== 1'b1) begin errs++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready_o); end
      vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      vecs++; if ({core_valid_o, rsp_valid_o} !== 2'b00) begin errs++; $display("FAIL reset_valids: got %b want 00", {core_valid_o, rsp_valid_o}); end
      vecs++; if ({rsp_data_o, rsp_err_o} !== 34'd0) begin errs++; $display("FAIL reset_rsp: got %h/%b want 0/00", rsp_data_o, rsp_err_o); end
      vecs++; if (fprti_regs_o !== '0) begin errs++; $display("FAIL reset_regs: got %h want 0", fprti_regs_o); end
   endtask

   task automatic test_full_op;
      int pulses;
      fill(15);
      vecs++; if (fprti_regs_o !== model) begin errs++; $display("FAIL fill_regs: got %h want %h", fprti_regs_o, model); end
      start_i = 1'b1;
      exp_q.push_back({32'h40400000, 2'b00});
      tick;
      start_i = 1'b0;
      vecs++; if (core_valid_o !== 1'b1) begin errs++; $display("FAIL issue_pulse: got %b want 1", core_valid_o); end
      vecs++; if (fprti_regs_o[14] !== 32'h41700000) begin errs++; $display("FAIL issue_reg14: got %h want 41700000", fprti_regs_o[14]); end
      pulses = 0;
      repeat (20) begin tick; pulses += int'(core_valid_o); end
      vecs++; if (pulses !== 0 || rsp_valid_o !== 1'b0) begin errs++; $display("FAIL wait_quiet: got pulses=%0d rsp_valid=%b want 0/0", pulses, rsp_valid_o); end
      core_result_i = 32'h40400000; core_valid_i = 1'b1;
      tick;
      core_valid_i = 1'b0;
      vecs++; if (rsp_valid_o !== 1'b1) begin errs++; $display("FAIL rsp_latency: got rsp_valid=%b want 1", rsp_valid_o); end
      vecs++; if (fprti_regs_o !== model) begin errs++; $display("FAIL regs_stable: got %h want %h", fprti_regs_o, model); end
      accept;
      vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL full_idle: got busy=%b want 0", busy_o); end
   endtask

   task automatic test_incomplete;
      clear_op;
      vecs++; if (fprti_regs_o !== '0) begin errs++; $display("FAIL clear_regs: got %h want 0", fprti_regs_o); end
      fill(14);
      start_i = 1'b1;
      exp_q.push_back({QNAN, 2'b01});
      tick;
      start_i = 1'b0;
      vecs++; if ({core_valid_o, rsp_valid_o} !== 2'b01) begin errs++; $display("FAIL incomplete_path: got core/rsp=%b want 01", {core_valid_o, rsp_valid_o}); end
      accept;
   endtask

   task automatic test_back_to_back;
      logic [31:0] r;
      wr_valid_i = 1'b1; wr_idx_i = 4'd14; wr_data_i = fl[14]; start_i = 1'b1;
      model[14] = fl[14];
      r = $urandom;
      exp_q.push_back({r, 2'b00});
      tick;
      wr_valid_i = 1'b0; start_i = 1'b0;
      vecs++; if (core_valid_o !== 1'b1 || fprti_regs_o !== model) begin errs++; $display("FAIL same_cycle_last: got core=%b regs=%h want 1/%h", core_valid_o, fprti_regs_o, model); end
      core_reply(r, 3);
      wr_valid_i = 1'b1; wr_idx_i = 4'd3; wr_data_i = 32'h3F800000; start_i = 1'b1;
      model[3] = 32'h3F800000;
      r = $urandom;
      exp_q.push_back({r, 2'b00});
      tick;
      wr_valid_i = 1'b0; start_i = 1'b0;
      vecs++; if (core_valid_o !== 1'b1 || fprti_regs_o[3] !== 32'h3F800000) begin errs++; $display("FAIL same_cycle_reg3: got core=%b reg3=%h want 1/3f800000", core_valid_o, fprti_regs_o[3]); end
      core_reply(r, $urandom_range(1, 6));
      clear_i = 1'b1; start_i = 1'b1;
      model = '0;
      exp_q.push_back({QNAN, 2'b01});
      tick;
      clear_i = 1'b0; start_i = 1'b0;
      vecs++; if ({core_valid_o, rsp_valid_o} !== 2'b01) begin errs++; $display("FAIL clear_start: got core/rsp=%b want 01", {core_valid_o, rsp_valid_o}); end
      accept;
      clear_i = 1'b1; wr_valid_i = 1'b1; wr_idx_i = 4'd0; wr_data_i = 32'hCAFEF00D;
      tick;
      clear_i = 1'b0; wr_valid_i = 1'b0;
      vecs++; if (fprti_regs_o[0] !== 32'd0) begin errs++; $display("FAIL clear_wins: got %h want 0", fprti_regs_o[0]); end
   endtask

   task automatic test_resp_hold;
      start_i = 1'b1;
      exp_q.push_back({QNAN, 2'b01});
      tick;
      for (int i = 0; i < 10; i++) begin
         wr_valid_i = 1'b1; wr_idx_i = 4'd5; wr_data_i = 32'h12345678; core_valid_i = 1'b1; core_result_i = 32'hBAD0BAD0;
         tick;
         vecs++;
         if ({rsp_valid_o, core_valid_o, rsp_data_o, rsp_err_o} !== {2'b10, QNAN, 2'b01} || fprti_regs_o !== model) begin
            errs++;
            $display("FAIL rsp_hold[%0d]: got v=%b c=%b %h/%b regs5=%h want 1/0 %h/01 regs5=%h", i, rsp_valid_o, core_valid_o, rsp_data_o, rsp_err_o, fprti_regs_o[5], QNAN, model[5]);
         end
      end
      start_i = 1'b0; wr_valid_i = 1'b0; core_valid_i = 1'b0;
      accept;
      vecs++; if (busy_o !== 1'b0 || fprti_regs_o[5] !== 32'd0) begin errs++; $display("FAIL hold_release: got busy=%b reg5=%h want 0/0", busy_o, fprti_regs_o[5]); end
      core_valid_i = 1'b1;
      tick;
      core_valid_i = 1'b0;
      vecs++; if ({busy_o, rsp_valid_o} !== 2'b00) begin errs++; $display("FAIL core_in_idle: got busy/rsp=%b want 00", {busy_o, rsp_valid_o}); end
   endtask

   task automatic test_reset_mid;
      int seen;
      fill(15);
      start_i = 1'b1;
      tick;
      start_i = 1'b0;
      tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      model = '0;
      vecs++; if (busy_o !== 1'b0 || fprti_regs_o !== '0) begin errs++; $display("FAIL reset_mid: got busy=%b regs=%h want 0/0", busy_o, fprti_regs_o); end
      core_valid_i = 1'b1; core_result_i = 32'h11111111;
      tick;
      core_valid_i = 1'b0;
      seen = 0;
      repeat (3) begin seen += int'(rsp_valid_o); tick; end
      vecs++; if (seen !== 0 || busy_o !== 1'b0) begin errs++; $display("FAIL late_core: got rsp cycles=%0d busy=%b want 0/0", seen, busy_o); end
      start_i = 1'b1;
      exp_q.push_back({QNAN, 2'b01});
      tick;
      start_i = 1'b0;
      vecs++; if (rsp_valid_o !== 1'b1) begin errs++; $display("FAIL mask_cleared: got rsp_valid=%b want 1", rsp_valid_o); end
      accept;
   endtask

   task automatic test_timeout;
      fill(15);
      start_i = 1'b1;
`ifdef FPRTI_CTRL_TIMEOUT_EN
      exp_q.push_back({QNAN, 2'b10});
`endif
      tick;
      start_i = 1'b0;
`ifdef FPRTI_CTRL_TIMEOUT_EN
      repeat (8) tick;
      vecs++; if ({busy_o, rsp_valid_o} !== 2'b10) begin errs++; $display("FAIL timeout_early: got busy/rsp=%b want 10", {busy_o, rsp_valid_o}); end
      tick;
      vecs++; if (rsp_valid_o !== 1'b1) begin errs++; $display("FAIL timeout_fire: got rsp_valid=%b want 1", rsp_valid_o); end
      accept;
      start_i = 1'b1;
      tick;
      start_i = 1'b0;
      repeat (8) tick;
      exp_q.push_back({32'h3F000000, 2'b00});
      core_reply(32'h3F000000, 0);
`else
      repeat (1000) tick;
      vecs++; if ({busy_o, rsp_valid_o} !== 2'b10) begin errs++; $display("FAIL no_timeout: got busy/rsp=%b want 10", {busy_o, rsp_valid_o}); end
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      model = '0;
`endif
   endtask

   initial begin
      test_reset;
      test_full_op;
      test_incomplete;
      test_back_to_back;
      test_resp_hold;
      test_reset_mid;
      test_timeout;
      repeat (2) tick;
      vecs++; if (exp_q.size() !== 0) begin errs++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
